// File: rtl/chip8_keypad_scanner.sv
// 4x4 hex keypad scanner: drives one row at a time, debounces every key and
// emits a debounced CHIP-8 key vector plus a one-cycle press event with its code.
module chip8_keypad_scanner #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        scan_enable,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic [15:0] key_state,
    output logic        key_press_valid,
    output logic [3:0]  key_press_code
);

    localparam int PH_W  = $clog2(SETTLE_CYCLES);
    localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    // Nibble (row*4 + col) holds the CHIP-8 code of that matrix position.
    localparam logic [63:0] KEY_MAP = 64'hFB0A_E987_D654_C321;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        row_q, row_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [3:0]        col_meta_q, col_sync_q;
    logic [CNT_W-1:0]  cnt_q [16];
    logic [CNT_W-1:0]  cnt_d [16];
    logic [15:0]       key_state_q, key_state_d;
    logic              press_valid_q, press_valid_d;
    logic [3:0]        press_code_q, press_code_d;

    logic              sample;
    logic [3:0]        key_idx;
    logic              raw;
    logic              found;

    assign sample = (state_q == ST_DRIVE) && scan_enable && (phase_q == PH_LAST);

    // NOTE: every variable gets its hold value first so no path through the
    // block leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        phase_d = phase_q;
        if (!scan_enable) begin
            state_d = ST_PAUSE;
            phase_d = '0;
        end else if (state_q == ST_PAUSE) begin
            state_d = ST_DRIVE;
            phase_d = '0;
        end else if (phase_q == PH_LAST) begin
            row_d   = row_q + 2'd1;
            phase_d = '0;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        key_state_d   = key_state_q;
        press_valid_d = 1'b0;
        press_code_d  = press_code_q;
        key_idx       = 4'h0;
        raw           = 1'b0;
        found         = 1'b0;
        if (sample) begin
            for (int c = 0; c < 4; c++) begin
                key_idx = KEY_MAP[{row_q, 2'(c), 2'b00} +: 4];
                raw     = ~col_sync_q[c];
                if (raw == key_state_q[key_idx]) begin
                    cnt_d[key_idx] = '0;
                end else if (cnt_q[key_idx] == CNT_LAST) begin
                    cnt_d[key_idx]       = '0;
                    key_state_d[key_idx] = raw;
                    // Only the lowest-column new press of this row is reported.
                    if (raw && !found) begin
                        found         = 1'b1;
                        press_valid_d = 1'b1;
                        press_code_d  = key_idx;
                    end
                end else begin
                    cnt_d[key_idx] = cnt_q[key_idx] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see
    // pre-edge values and simulation matches the synthesized registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q       <= ST_DRIVE;
            row_q         <= 2'd0;
            phase_q       <= '0;
            col_meta_q    <= 4'hF;
            col_sync_q    <= 4'hF;
            key_state_q   <= '0;
            press_valid_q <= 1'b0;
            press_code_q  <= 4'h0;
            // NOTE: the debounce counter array is reset explicitly so a reset
            // mid-debounce discards partial progress toward a flip.
            for (int k = 0; k < 16; k++) cnt_q[k] <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            phase_q       <= phase_d;
            col_meta_q    <= col_n;
            col_sync_q    <= col_meta_q;
            key_state_q   <= key_state_d;
            press_valid_q <= press_valid_d;
            press_code_q  <= press_code_d;
            cnt_q         <= cnt_d;
        end
    end

    assign row_n           = (state_q == ST_DRIVE) ? ~(4'b0001 << row_q) : 4'hF;
    assign key_state       = key_state_q;
    assign key_press_valid = press_valid_q;
    assign key_press_code  = press_code_q;

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// Self-checking bench for chip8_keypad_scanner: a keypad matrix model drives the
// columns from row_n, and expected press codes are queued and matched on each pulse.
module tb_chip8_keypad_scanner;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        scan_enable;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] key_state;
    logic        key_press_valid;
    logic [3:0]  key_press_code;

    logic [15:0] pressed;
    logic [3:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;

    chip8_keypad_scanner #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .scan_enable     (scan_enable),
        .col_n           (col_n),
        .row_n           (row_n),
        .key_state       (key_state),
        .key_press_valid (key_press_valid),
        .key_press_code  (key_press_code)
    );

    always #5 clk_clk = ~clk_clk;

    function automatic logic [3:0] key_at(input int r, input int c);
        case (r * 4 + c)
            0:  return 4'h1;  1:  return 4'h2;  2:  return 4'h3;  3:  return 4'hC;
            4:  return 4'h4;  5:  return 4'h5;  6:  return 4'h6;  7:  return 4'hD;
            8:  return 4'h7;  9:  return 4'h8;  10: return 4'h9;  11: return 4'hE;
            12: return 4'hA;  13: return 4'h0;  14: return 4'hB;  default: return 4'hF;
        endcase
    endfunction

    // Passive keypad: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && pressed[key_at(r, c)]) col_n[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns on the first negedge after row r has been driven and sampled.
    task automatic wait_row_done(input logic [1:0] r);
        logic [3:0] pat;
        int n;
        pat = ~(4'b0001 << r);
        n = 0;
        while (row_n !== pat && n < 64) begin
            @(negedge clk_clk);
            n++;
        end
        check("row_enter", 32'(row_n), 32'(pat));
        n = 0;
        while (row_n === pat && n < 64) begin
            @(negedge clk_clk);
            n++;
        end
        check("row_leave", 32'(row_n !== pat), 32'd1);
    endtask

    task automatic wait_rows(input logic [1:0] r, input int times);
        for (int i = 0; i < times; i++) wait_row_done(r);
    endtask

    always @(negedge clk_clk) begin
        if (!reset_reset && key_press_valid) begin
            if (exp_q.size() == 0)
                check("press_expected", 32'd0, 32'd1);
            else
                check("press_code", 32'(key_press_code), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_row;
        reset_reset = 1'b1;
        scan_enable = 1'b1;
        pressed     = 16'h0;
        repeat (2) @(negedge clk_clk);
        check("rst_row_n", 32'(row_n), 32'hE);
        check("rst_key_state", 32'(key_state), 32'h0);
        check("rst_valid", 32'(key_press_valid), 32'h0);
        reset_reset = 1'b0;

        for (int i = 1; i <= 17; i++) begin
            @(negedge clk_clk);
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            check("row_seq", 32'(row_n), 32'(exp_row));
        end

        // Key 6 held: flips on the third row-1 sample, single event.
        pressed[6] = 1'b1;
        exp_q.push_back(4'h6);
        wait_rows(2'd1, 2);
        check("k6_after2", 32'(key_state), 32'h0);
        wait_row_done(2'd1);
        check("k6_after3", 32'(key_state), 32'h0040);
        wait_rows(2'd1, 2);
        check("k6_held", 32'(key_state), 32'h0040);

        // Release: no event, clears on the third sample.
        pressed[6] = 1'b0;
        wait_rows(2'd1, 2);
        check("k6_rel2", 32'(key_state), 32'h0040);
        wait_row_done(2'd1);
        check("k6_rel3", 32'(key_state), 32'h0);

        // Glitch lasting two samples never reaches key_state.
        pressed[6] = 1'b1;
        wait_rows(2'd1, 2);
        pressed[6] = 1'b0;
        wait_rows(2'd1, 2);
        check("glitch", 32'(key_state), 32'h0);

        // Keys 1 and 2 together: one event, lowest column wins.
        pressed = 16'h0006;
        exp_q.push_back(4'h1);
        wait_rows(2'd0, 3);
        check("k12_state", 32'(key_state), 32'h0006);
        @(negedge clk_clk);
        check("k12_code_hold", 32'(key_press_code), 32'h1);
        check("k12_pulse_len", 32'(key_press_valid), 32'h0);
        pressed = 16'h0;
        wait_rows(2'd0, 3);
        check("k12_release", 32'(key_state), 32'h0);

        // Key 0 lives at row 3, column 1.
        pressed = 16'h0001;
        exp_q.push_back(4'h0);
        wait_rows(2'd3, 3);
        check("k0_state", 32'(key_state), 32'h0001);
        pressed = 16'h0;
        wait_rows(2'd3, 3);
        check("k0_release", 32'(key_state), 32'h0);

        // Pause at debounce count 2, then resume at the held row.
        pressed[6] = 1'b1;
        exp_q.push_back(4'h6);
        wait_rows(2'd1, 2);
        check("pause_pre", 32'(key_state), 32'h0);
        scan_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_clk);
            check("pause_row_n", 32'(row_n), 32'hF);
            check("pause_state", 32'(key_state), 32'h0);
        end
        scan_enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk_clk);
            check("resume_row", 32'(row_n), (i <= 4) ? 32'hB : 32'h7);
        end
        wait_row_done(2'd1);
        check("pause_flip", 32'(key_state), 32'h0040);
        pressed[6] = 1'b0;
        wait_rows(2'd1, 3);
        check("pause_release", 32'(key_state), 32'h0);

        // Reset at debounce count 2 discards progress.
        pressed[6] = 1'b1;
        wait_rows(2'd1, 2);
        reset_reset = 1'b1;
        repeat (2) @(negedge clk_clk);
        check("mid_rst_row_n", 32'(row_n), 32'hE);
        check("mid_rst_state", 32'(key_state), 32'h0);
        check("mid_rst_valid", 32'(key_press_valid), 32'h0);
        check("mid_rst_code", 32'(key_press_code), 32'h0);
        reset_reset = 1'b0;
        exp_q.push_back(4'h6);
        wait_rows(2'd1, 2);
        check("post_rst2", 32'(key_state), 32'h0);
        wait_row_done(2'd1);
        check("post_rst3", 32'(key_state), 32'h0040);
        pressed[6] = 1'b0;
        wait_rows(2'd1, 3);
        check("post_rst_rel", 32'(key_state), 32'h0);

        // All sixteen keys at once, starting on row 0.
        wait_row_done(2'd3);
        pressed = 16'hFFFF;
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h4);
        exp_q.push_back(4'h7);
        exp_q.push_back(4'hA);
        wait_rows(2'd3, 3);
        check("all_keys", 32'(key_state), 32'hFFFF);
        @(negedge clk_clk);
        pressed = 16'h0;
        wait_rows(2'd3, 3);
        check("all_release", 32'(key_state), 32'h0);
        @(negedge clk_clk);
        check("events_left", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chip8_keypad_scanner.md
Name: chip8_keypad_scanner

Overview:
Scans a 4x4 hex keypad matrix, debounces each key and presents a 16-bit debounced key vector in CHIP-8 key order. The vector feeds the system's 16-bit switch_control input directly upstream of the CPU system. A one-cycle press event carries the key code so the CPU can service the wait-for-key instruction (FX0A) without polling.

Parameters:
SETTLE_CYCLES, 1000, clock cycles each row is driven before its columns are sampled; must be >= 3.
DEBOUNCE_SCANS, 4, consecutive disagreeing samples needed to flip a key's debounced state; must be >= 1.

Ports:
clk_clk  input  1  system clock; sole clock domain.
reset_reset  input  1  synchronous, active-high reset.
scan_enable  input  1  1 = scanning active; 0 = scan paused.
col_n  input  4  raw asynchronous column inputs, active-low (0 = contact closed), externally pulled up.
row_n  output  4  row drive, active-low; at most one bit is 0 at a time.
key_state  output  16  debounced key vector; bit k = 1 means CHIP-8 key k is held; connects to switch_control.
key_press_valid  output  1  one-cycle pulse on a debounced 0->1 transition.
key_press_code  output  4  CHIP-8 code of the pressed key; valid while key_press_valid = 1, otherwise holds its last value.

Behaviour:
- Reset values (synchronous): row_n = 4'b1110, row index 0, phase counter 0, col synchronizer = 4'hF, all debounce counters 0, key_state = 0, key_press_valid = 0, key_press_code = 0. Reset mid-scan or mid-debounce discards all progress.
- Synchronizer: col_n passes through 2 flops. Only the synchronized value is used.
- Scan FSM states: DRIVE(r) for r = 0..3.
  - In DRIVE(r), row_n has bit r = 0. The phase counter counts 0..SETTLE_CYCLES-1.
  - On the cycle the counter = SETTLE_CYCLES-1, the synchronized columns are sampled for row r. The next cycle the FSM moves to DRIVE((r+1) mod 4), wrapping 3 -> 0, and the counter returns to 0.
  - One frame = 4*SETTLE_CYCLES cycles.
- Matrix mapping, [row][col0..col3] -> CHIP-8 key:
  - row0: 1, 2, 3, C
  - row1: 4, 5, 6, D
  - row2: 7, 8, 9, E
  - row3: A, 0, B, F
- Debounce, per key, evaluated only on that key's row sample:
  - raw = ~col_sync[c].
  - If raw == key_state bit: counter is cleared to 0.
  - Else if counter == DEBOUNCE_SCANS-1: key_state bit flips and counter is cleared.
  - Else: counter increments.
  - key_state updates on the cycle after the sample.
- Press event:
  - On the same cycle key_state updates, if one or more keys of that row flip 0->1, key_press_valid = 1 for exactly one cycle.
  - key_press_code = the code of the lowest-column flipping key.
  - Other simultaneous presses still appear in key_state but get no event.
  - Releases (1->0) never generate an event.
- scan_enable = 0:
  - The next cycle row_n = 4'hF and the phase counter = 0.
  - Row index, debounce counters and key_state hold. No samples and no events occur.
  - On return to 1, the FSM restarts DRIVE at the held row with a full settle period.
- Boundary cases:
  - A glitch shorter than DEBOUNCE_SCANS samples never changes key_state.
  - All 16 keys held at once is legal and gives key_state = 16'hFFFF.
  - Ghosting in the matrix is not compensated.

Test Plan:
Bench settings: SETTLE_CYCLES = 4, DEBOUNCE_SCANS = 3 (frame = 16 cycles).
1. Assert reset_reset for 2 cycles, col_n = 4'hF -> row_n = 4'b1110, key_state = 0, key_press_valid = 0. row_n then cycles 1101, 1011, 0111, 1110 every 4 cycles.
2. Hold col_n[2] = 0 whenever row_n[1] = 0 (key 6) -> after the 3rd row-1 sample, key_state = 16'h0040 and one key_press_valid pulse with key_press_code = 4'h6. No further pulses while held.
3. Key 6 pressed for only 2 row-1 samples, then released -> key_state stays 0, no pulse.
4. Release key 6 after step 2 -> key_state = 0 after 3 row-1 samples, no pulse.
5. Keys 1 and 2 (row0 col0, col1) pressed together -> key_state = 16'h0006, single pulse with code 1. Key 0 (row3 col1) alone -> key_state = 16'h0001, code 0.
6. During step 2 at debounce count 2:
   - Drop scan_enable for 10 cycles -> row_n = 4'hF throughout and key_state unchanged. After re-enable, the held row gets a full 4-cycle settle.
   - Assert reset instead -> all outputs return to their reset values, and the full 3-sample debounce is required afterwards.
